aes_inv_round_seq: RTL and testbench
====================================

AES_INV_ROUND_SEQ -- requirements
Module: aes_inv_round_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  state_in/rkey_in valid.
REQ-005 in_ready  output  1  block can accept a round job.
REQ-006 state_in  input  128  cipher state; column sW = state_in[127-32W -: 32]; byte k of a column = bits [31-8k -: 8].
REQ-007 rkey_in  input  128  round key, same column layout.
REQ-008 td_addr  output  8  address to the external Td0 ROM.
REQ-009 td_q  input  32  Td0 ROM data, registered in ROM, valid one cycle after td_addr.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 state_out  output  128  inverse-round result, same column layout.

Function
REQ-013 The block SHALL compute one non-final AES inverse round: t_j = Td0[b0(s_j)] ^ ror8(Td0[b1(s_(j-1)mod4)]) ^ ror16(Td0[b2(s_(j-2)mod4)]) ^ ror24(Td0[b3(s_(j-3)mod4)]) ^ rk_j, where rorN is a 32-bit rotate right by N.
REQ-014 FSM states SHALL be IDLE, RUN, FLUSH, HOLD; in_ready = (state==IDLE).
REQ-015 IDLE: on in_valid&in_ready, the block SHALL capture state_in, load a 128-bit accumulator with rkey_in, clear 4-bit counter i, and go to RUN.
REQ-016 RUN: td_addr SHALL equal byte k of column (j-k) mod 4 of the captured state, with j=i[3:2], k=i[1:0]; i increments each cycle; after i=15 the state goes to FLUSH.
REQ-017 Each cycle after a lookup is issued, the block SHALL XOR rorR(td_q) into accumulator column j of that lookup, with R=8k, using a one-cycle-delayed copy of (j,k) and a delayed valid flag.
REQ-018 FLUSH: the block SHALL accumulate lookup 15, set out_valid, and go to HOLD on the same edge.
REQ-019 Latency: out_valid SHALL rise exactly 17 rising edges after the accepting edge.
REQ-020 HOLD: state_out SHALL equal the accumulator, stable while out_valid&!out_ready; on out_valid&out_ready, out_valid clears and the state returns to IDLE.
REQ-021 No new job SHALL be accepted in RUN, FLUSH, or HOLD; minimum job spacing is 18 cycles.
REQ-022 td_addr SHALL be 8'h00 in IDLE, FLUSH and HOLD.
REQ-023 in_valid deasserted in IDLE SHALL leave all outputs unchanged.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, i=0, out_valid=0, state_out=0, td_addr=0, and accumulator/capture registers=0.
REQ-025 Reset mid-RUN or in HOLD SHALL discard the job with no out_valid pulse; after release, in_ready=1 on the first cycle.

Verification
REQ-026 state_in=0, rkey_in=0 -> after 17 edges, state_out=128'h52525252_52525252_52525252_52525252.
REQ-027 state_in=all bytes 8'h63 (Td0[0x63]=0), rkey_in=128'h00112233_44556677_8899aabb_ccddeeff -> state_out equals rkey_in.
REQ-028 state_in=128'h01000000_00000000_00000000_00000000, rkey_in=0 -> state_out=128'h7de79051_52525252_52525252_52525252; td_addr sequence is 01,00,00,00, then 0x00 for the remaining lookups.
REQ-029 state_in=128'h00010203_04050607_08090a0b_0c0d0e0f -> first four td_addr values are 00,0d,0a,07 (b0 s0, b1 s3, b2 s2, b3 s1).
REQ-030 Hold out_ready=0 for 5 cycles after out_valid -> state_out stable, in_ready=0, and in_valid pulses are ignored; job completes on the out_ready=1 edge.
REQ-031 Assert rst_n=0 at RUN i=7 -> out_valid=0 immediately; a new zero job after release yields REQ-026 values at the correct latency.

Source files
------------

// File: rtl/aes_inv_round_seq.sv
// Sequential AES inverse round (non-final): sixteen Td0 lookups through an external
// registered ROM, XOR-accumulated column by column on top of the round key.
module aes_inv_round_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey_in,
  output logic [7:0]   td_addr,
  input  logic [31:0]  td_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg;
  logic [127:0]  cap_reg;
  logic [127:0]  acc_reg, acc_next;
  logic          pend_valid_reg;
  logic [1:0]    pend_j_reg, pend_k_reg;
  logic          out_valid_reg;

  logic          accept;
  logic [1:0]    cur_j, cur_k, src_col;
  logic [31:0]   src_word;
  logic [7:0]    src_byte;
  logic [31:0]   rot_q;
  logic [31:0]   cap_col [4];

  assign accept   = in_valid && (state_reg == IDLE);
  assign cur_j    = cnt_reg[3:2];
  assign cur_k    = cnt_reg[1:0];
  assign src_col  = cur_j - cur_k;  // 2-bit wrap gives (j-k) mod 4

  for (genvar gi = 0; gi < 4; gi++) begin : g_cap_col
    assign cap_col[gi] = cap_reg[127-32*gi -: 32];
  end

  always_comb begin
    src_word = cap_col[src_col];
    case (cur_k)
      2'd0:    src_byte = src_word[31:24];
      2'd1:    src_byte = src_word[23:16];
      2'd2:    src_byte = src_word[15:8];
      default: src_byte = src_word[7:0];
    endcase
  end

  assign td_addr = (state_reg == RUN) ? src_byte : 8'h00;

  // ROM data belongs to the lookup issued one cycle earlier, so rotate by its delayed k
  always_comb begin
    case (pend_k_reg)
      2'd0:    rot_q = td_q;
      2'd1:    rot_q = {td_q[7:0],  td_q[31:8]};
      2'd2:    rot_q = {td_q[15:0], td_q[31:16]};
      default: rot_q = {td_q[23:0], td_q[31:24]};
    endcase
  end

  always_comb begin
    acc_next = acc_reg;
    if (accept) begin
      acc_next = rkey_in;
    end else if (pend_valid_reg) begin
      case (pend_j_reg)
        2'd0:    acc_next[127:96] = acc_reg[127:96] ^ rot_q;
        2'd1:    acc_next[95:64]  = acc_reg[95:64]  ^ rot_q;
        2'd2:    acc_next[63:32]  = acc_reg[63:32]  ^ rot_q;
        default: acc_next[31:0]   = acc_reg[31:0]   ^ rot_q;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (cnt_reg == 4'd15) state_next = FLUSH;
      FLUSH:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= 4'd0;
      cap_reg        <= 128'd0;
      acc_reg        <= 128'd0;
      pend_valid_reg <= 1'b0;
      pend_j_reg     <= 2'd0;
      pend_k_reg     <= 2'd0;
      out_valid_reg  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg <= 4'd0;
        cap_reg <= state_in;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      acc_reg        <= acc_next;
      pend_valid_reg <= (state_reg == RUN);
      pend_j_reg     <= cur_j;
      pend_k_reg     <= cur_k;
      out_valid_reg  <= (state_next == HOLD);
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign state_out = acc_reg;

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Bench for aes_inv_round_seq: Td0 ROM built from GF(2^8) arithmetic, table-driven jobs
// checked through a scoreboard queue, plus back-pressure and mid-run reset sequences.
module tb_aes_inv_round_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] rkey_in = '0;
  logic [7:0]   td_addr;
  logic [31:0]  td_q = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;

  aes_inv_round_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .rkey_in(rkey_in), .td_addr(td_addr), .td_q(td_q),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
  );

  always #5 clk = ~clk;

  logic [31:0] td0 [256];
  always @(posedge clk) td_q <= td0[td_addr];

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] sb_q [$];
  logic [7:0]   last_addr [16];

  typedef struct {
    logic [127:0] s;
    logic [127:0] rk;
    logic [127:0] exp;
    int           hold;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0] sbyte(input logic [127:0] s, input int col, input int k);
    return s[127 - 32*col - 8*k -: 8];
  endfunction

  // Reference inverse round straight from the column equation
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) begin
      r[127 - 32*j -: 32] = td0[sbyte(s, j, 0)]
                          ^ ror(td0[sbyte(s, (j + 3) % 4, 1)], 8)
                          ^ ror(td0[sbyte(s, (j + 2) % 4, 2)], 16)
                          ^ ror(td0[sbyte(s, (j + 1) % 4, 3)], 24)
                          ^ rk[127 - 32*j -: 32];
    end
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
  endtask

  task automatic run_job(input int id, input logic [127:0] s, input logic [127:0] rk,
                         input logic [127:0] exp, input int hold);
    bit ok;
    int n;
    logic [127:0] snap, want;
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1; state_in = s; rkey_in = rk; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; state_in = {$urandom, $urandom, $urandom, $urandom};
    sb_q.push_back(exp);
    last_addr[0] = td_addr;
    n = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      n = e;
      if (e < 16) last_addr[e] = td_addr;
      if (e == 16) chk("td_addr_flush", {120'd0, td_addr}, 128'd0);
      if (out_valid === 1'b1) break;
    end
    chk("latency", n, 17);
    for (int i = 0; i < 16; i++)
      chk("td_addr_seq", {120'd0, last_addr[i]}, {120'd0, sbyte(s, ((i / 4) - (i % 4) + 4) % 4, i % 4)});
    if (out_valid !== 1'b1) begin
      void'(sb_q.pop_front());
      return;
    end
    snap = state_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; state_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_stable", state_out, snap);
      chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
      chk("hold_out_valid", {127'd0, out_valid}, 128'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 128'd1, 128'd0);
    end else begin
      want = sb_q.pop_front();
      chk("state_out", state_out, want);
    end
    $display("job %0d: state_in=%h rkey=%h state_out=%h hold=%0d", id, s, rk, state_out, hold);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_clear", {127'd0, out_valid}, 128'd0);
    chk("in_ready_after", {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    logic [7:0] isb [256];
    bit ok;
    for (int x = 0; x < 256; x++) isb[sbox(x[7:0])] = x[7:0];
    for (int x = 0; x < 256; x++)
      td0[x] = {gmul(isb[x], 8'h0e), gmul(isb[x], 8'h09), gmul(isb[x], 8'h0d), gmul(isb[x], 8'h0b)};

    vecs[0] = '{128'd0, 128'd0, {4{32'h52525252}}, 0};
    vecs[1] = '{{16{8'h63}}, 128'h00112233_44556677_8899aabb_ccddeeff,
                128'h00112233_44556677_8899aabb_ccddeeff, 0};
    vecs[2] = '{128'h01000000_00000000_00000000_00000000, 128'd0,
                128'h7de79051_52525252_52525252_52525252, 0};
    vecs[3] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'd0, 128'd0, 5};
    vecs[4] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 128'd0, 0};
    vecs[5] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 128'd0, 2};
    vecs[6] = '{128'h00112233_44556677_8899aabb_ccddeeff, {4{32'hdeadbeef}}, 128'd0, 0};
    for (int r = 3; r < 7; r++) vecs[r].exp = inv_round(vecs[r].s, vecs[r].rk);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_state_out", state_out, 128'd0);
    chk("reset_td_addr", {120'd0, td_addr}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_state_out", state_out, 128'd0);

    for (int r = 0; r < 7; r++) begin
      run_job(r, vecs[r].s, vecs[r].rk, vecs[r].exp, vecs[r].hold);
      if (r == 2) begin
        chk("req028_addr0", {120'd0, last_addr[0]}, 128'h01);
        for (int i = 1; i < 16; i++) chk("req028_addr_zero", {120'd0, last_addr[i]}, 128'd0);
      end
      if (r == 3) begin
        chk("req029_addr0", {120'd0, last_addr[0]}, 128'h00);
        chk("req029_addr1", {120'd0, last_addr[1]}, 128'h0d);
        chk("req029_addr2", {120'd0, last_addr[2]}, 128'h0a);
        chk("req029_addr3", {120'd0, last_addr[3]}, 128'h07);
      end
      if (vecs[r].hold > 0) begin
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("no_ghost_job", {127'd0, ok}, 128'd1);
      end
    end

    // Reset while RUN is at i=7 discards the job
    wait_ready(ok);
    in_valid = 1'b1; state_in = vecs[5].s; rkey_in = vecs[5].rk;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrun_in_ready", {127'd0, in_ready}, 128'd1);
    chk("midrun_td_addr", {120'd0, td_addr}, 128'd0);
    chk("midrun_state_out", state_out, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("release_in_ready", {127'd0, in_ready}, 128'd1);
    run_job(7, 128'd0, 128'd0, {4{32'h52525252}}, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
